mix_col_engine: RTL and testbench

Sequential, parametrised MixColumns/InvMixColumns engine for the AES-128 datapath. Accepts one 128-bit state per transaction over a valid/ready handshake. Processes COLS_PER_CYC columns per clock, time-sharing the GF(2^8) column logic, and returns the result over a back-pressurable output port. Sits between shift-rows and add-round-key in the round iterator; a per-transaction bypass mode serves the final round.

---
 rtl/mix_col_engine.sv | 178 +++++++++++++++++
 tb/tb_mix_col_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mix_col_engine.sv
// AES MixColumns/InvMixColumns/bypass engine, COLS_PER_CYC columns per clock; result after 4/COLS_PER_CYC clocks (bypass 1).
// valid/ready both sides; result holds until out_ready, and in DONE in_ready follows out_ready for back-to-back acceptance.
module mix_col_engine #(
    parameter int COLS_PER_CYC = 1,
    parameter bit OUT_REG      = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_mode,
    input  logic [0:127] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
    output logic         busy
);

    if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4)) begin : g_bad_cols
        $error("mix_col_engine: COLS_PER_CYC must be 1, 2 or 4");
    end
    if (!OUT_REG && COLS_PER_CYC != 4) begin : g_bad_outreg
        $error("mix_col_engine: OUT_REG=0 requires COLS_PER_CYC=4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] LAST = 2'(4 / COLS_PER_CYC - 1);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m3(input logic [7:0] b);
        return xt(b) ^ b;
    endfunction

    function automatic logic [7:0] m9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] md(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] me(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // Row 0 of a column sits in the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        if (inv) begin
            return {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
                    m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
                    md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
                    mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)};
        end
        return {xt(a0) ^ m3(a1) ^ a2 ^ a3,
                a0 ^ xt(a1) ^ m3(a2) ^ a3,
                a0 ^ a1 ^ xt(a2) ^ m3(a3),
                m3(a0) ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [0:127]   work_q, work_d;
    logic [0:127]   out_q, out_d;
    logic           inv_q, inv_d;

    logic           in_busy;
    logic [0:127]   src;
    logic [1:0]     pass_idx;
    logic           inv_sel;
    logic [0:127]   pass_res;
    logic           rdy_fsm;
    logic           accept;

    // The first pass runs on the accept edge straight from in_state, later passes from the working register.
    assign in_busy  = (state_q == BUSY);
    assign src      = in_busy ? work_q : in_state;
    assign pass_idx = in_busy ? cnt_q : 2'd0;
    assign inv_sel  = in_busy ? inv_q : (in_mode == 2'b01);

    always_comb begin
        pass_res = src;
        for (int j = 0; j < COLS_PER_CYC; j++) begin
            pass_res[(int'(pass_idx) * COLS_PER_CYC + j) * 32 +: 32] =
                mix_col(src[(int'(pass_idx) * COLS_PER_CYC + j) * 32 +: 32], inv_sel);
        end
    end

    assign rdy_fsm = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept  = in_valid && rdy_fsm;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        out_d   = out_q;
        inv_d   = inv_q;
        case (state_q)
            BUSY: begin
                work_d = pass_res;
                if (cnt_q == LAST) begin
                    out_d   = pass_res;
                    cnt_d   = 2'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                if (accept) begin
                    inv_d = (in_mode == 2'b01);
                    if (in_mode[1]) begin
                        work_d  = in_state;
                        out_d   = in_state;
                        state_d = DONE;
                    end else if (LAST == 2'd0) begin
                        work_d  = pass_res;
                        out_d   = pass_res;
                        state_d = DONE;
                    end else begin
                        work_d  = pass_res;
                        cnt_d   = 2'd1;
                        state_d = BUSY;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            work_q <= '0;
            out_q  <= '0;
            inv_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            work_q <= work_d;
            out_q  <= out_d;
            inv_q  <= inv_d;
        end
    end

    if (OUT_REG) begin : g_out_reg
        assign out_valid = (state_q == DONE);
        assign in_ready  = rdy_fsm;
        assign out_state = out_q;
        assign busy      = (state_q != IDLE);
    end else begin : g_out_comb
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
        assign out_state = in_mode[1] ? in_state : pass_res;
        assign busy      = in_valid;
    end

endmodule

// File: tb/tb_mix_col_engine.sv
// Directed bench: FIPS-197 and column vectors across COLS_PER_CYC 1/2/4 plus a combinational instance,
// with bypass, back-pressure and mid-transaction reset.
module tb_mix_col_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   in_mode;
    logic [0:127] in_state;
    logic         out_ready;
    logic         iv [4];
    logic         ir [4];
    logic         ov [4];
    logic [0:127] os [4];
    logic         bz [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mix_col_engine #(.COLS_PER_CYC(1), .OUT_REG(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_mode(in_mode),
        .in_state(in_state), .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]), .busy(bz[0]));
    mix_col_engine #(.COLS_PER_CYC(2), .OUT_REG(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_mode(in_mode),
        .in_state(in_state), .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]), .busy(bz[1]));
    mix_col_engine #(.COLS_PER_CYC(4), .OUT_REG(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_mode(in_mode),
        .in_state(in_state), .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]), .busy(bz[2]));
    mix_col_engine #(.COLS_PER_CYC(4), .OUT_REG(1'b0)) dutc (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_mode(in_mode),
        .in_state(in_state), .out_valid(ov[3]), .out_ready(out_ready), .out_state(os[3]), .busy(bz[3]));

    task automatic chk_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Latency counts clock edges from the accept edge (inclusive) to out_valid.
    task automatic run_txn(input int d, input logic [1:0] m, input logic [0:127] st,
                           input logic [0:127] exp, input int lat, input string tag);
        int cyc;
        @(negedge clk);
        in_mode  = m;
        in_state = st;
        iv[d]    = 1'b1;
        @(posedge clk);
        #1;
        iv[d]    = 1'b0;
        in_state = ~st;
        in_mode  = ~m;
        cyc = 1;
        while (ov[d] !== 1'b1 && cyc < 32) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk_int({tag, "_lat"}, cyc, lat);
        chk_vec({tag, "_dat"}, os[d], exp);
    endtask

    localparam logic [0:127] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [0:127] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [0:127] COLA_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [0:127] COLA_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [0:127] COLB_IN  = 128'hd4d4d4d52d26314c01010101c6c6c6c6;
    localparam logic [0:127] COLB_OUT = 128'hd5d5d7d64d7ebdf801010101c6c6c6c6;

    initial begin
        logic [0:127] rnd;
        int cyc;
        rst_n     = 1'b0;
        in_mode   = 2'b00;
        in_state  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) iv[i] = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_bit($sformatf("rst_out_valid%0d", i), ov[i], 1'b0);
            chk_vec($sformatf("rst_out_state%0d", i), os[i], '0);
            chk_bit($sformatf("rst_in_ready%0d", i), ir[i], 1'b1);
            chk_bit($sformatf("rst_busy%0d", i), bz[i], 1'b0);
        end

        run_txn(0, 2'b00, FIPS_IN,  FIPS_OUT, 4, "fips_fwd_c1");
        run_txn(0, 2'b01, FIPS_OUT, FIPS_IN,  4, "fips_inv_c1");
        run_txn(1, 2'b00, FIPS_IN,  FIPS_OUT, 2, "fips_fwd_c2");
        run_txn(1, 2'b01, FIPS_OUT, FIPS_IN,  2, "fips_inv_c2");
        run_txn(2, 2'b00, FIPS_IN,  FIPS_OUT, 1, "fips_fwd_c4");
        run_txn(2, 2'b01, FIPS_OUT, FIPS_IN,  1, "fips_inv_c4");
        run_txn(1, 2'b00, COLA_IN,  COLA_OUT, 2, "cola_fwd_c2");
        run_txn(2, 2'b00, COLB_IN,  COLB_OUT, 1, "colb_fwd_c4");
        run_txn(0, 2'b01, COLB_OUT, COLB_IN,  4, "colb_inv_c1");
        run_txn(0, 2'b00, COLA_IN,  COLA_OUT, 4, "cola_fwd_c1");

        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_txn(0, 2'b10, rnd, rnd, 1, "bypass10_c1");
        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_txn(0, 2'b11, rnd, rnd, 1, "bypass11_c1");
        run_txn(1, 2'b10, COLA_IN, COLA_IN, 1, "bypass10_c2");

        // Back-pressure then back-to-back acceptance from DONE.
        @(negedge clk);
        out_ready = 1'b0;
        run_txn(0, 2'b00, FIPS_IN, FIPS_OUT, 4, "bp_first");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk_bit($sformatf("bp_valid_hold%0d", k), ov[0], 1'b1);
            chk_vec($sformatf("bp_state_hold%0d", k), os[0], FIPS_OUT);
            chk_bit($sformatf("bp_in_ready%0d", k), ir[0], 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_mode   = 2'b01;
        in_state  = FIPS_OUT;
        iv[0]     = 1'b1;
        #1;
        chk_bit("b2b_in_ready", ir[0], 1'b1);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk_bit("b2b_accepted_valid", ov[0], 1'b0);
        chk_bit("b2b_accepted_busy", bz[0], 1'b1);
        cyc = 1;
        while (ov[0] !== 1'b1 && cyc < 32) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk_int("b2b_lat", cyc, 4);
        chk_vec("b2b_dat", os[0], FIPS_IN);

        // Reset while the counter sits at 2.
        @(negedge clk);
        in_mode  = 2'b00;
        in_state = COLB_IN;
        iv[0]    = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        #1;
        chk_bit("midrst_busy_before", bz[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk_bit("midrst_out_valid", ov[0], 1'b0);
        chk_vec("midrst_out_state", os[0], '0);
        chk_bit("midrst_busy", bz[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(0, 2'b00, COLB_IN, COLB_OUT, 4, "after_rst_c1");

        // Combinational instance: zero latency, ready follows out_ready.
        @(negedge clk);
        in_mode   = 2'b00;
        in_state  = FIPS_IN;
        iv[3]     = 1'b1;
        out_ready = 1'b0;
        #1;
        chk_vec("comb_fwd_dat", os[3], FIPS_OUT);
        chk_bit("comb_out_valid", ov[3], 1'b1);
        chk_bit("comb_in_ready_lo", ir[3], 1'b0);
        out_ready = 1'b1;
        in_mode   = 2'b01;
        in_state  = COLB_OUT;
        #1;
        chk_bit("comb_in_ready_hi", ir[3], 1'b1);
        chk_vec("comb_inv_dat", os[3], COLB_IN);
        in_mode = 2'b10;
        #1;
        chk_vec("comb_bypass_dat", os[3], COLB_OUT);
        iv[3] = 1'b0;
        #1;
        chk_bit("comb_out_valid_lo", ov[3], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
